router_out_fifo: RTL
====================

# router_out_fifo

Per-port output FIFO of the 1x3 router. It sits directly downstream of the register stage and buffers the header, payload and parity bytes on the register stage's `dout` bus for one destination port. It tags each header byte so the read side can count packet length. Its `full` flag goes back to the register stage and FSM to stall loading, and its `empty` flag tells the synchroniser that data is waiting for the destination.

## Interface
- `DEPTH`, 16, number of entries; must be a power of two, at least 4.
- `WIDTH`, 8, data byte width. Each stored entry is WIDTH+1 bits wide: the data byte plus a header tag.
- `AW`, $clog2(DEPTH), address width. Derived; not overridden.
- `clock`  in  1  single clock; all state changes on its rising edge.
- `reset`  in  1  asynchronous, active-high reset.
- `soft_reset`  in  1  synchronous flush, driven by the synchroniser on a read timeout.
- `write_enb`  in  1  write request from the synchroniser's per-port decode.
- `lfd_state`  in  1  high on the header write cycle; sets the stored tag bit.
- `data_in`  in  WIDTH  byte from the register stage's `dout`.
- `read_enb`  in  1  read request from the destination.
- `data_out`  out  WIDTH  registered read data.
- `out_valid`  out  1  one-cycle pulse: `data_out` was updated this cycle.
- `pkt_done`  out  1  one-cycle pulse, coincident with the `out_valid` of a packet's parity byte.
- `full`  out  1  occupancy equals DEPTH.
- `empty`  out  1  occupancy equals 0.
- `level`  out  AW+1  current occupancy.

## Operation
- **Storage and pointers**
  - Storage: DEPTH x (WIDTH+1) array.
  - Pointers: AW+1-bit `wr_ptr`/`rd_ptr`; the extra MSB disambiguates full from empty; pointers wrap naturally.
  - `level` = `wr_ptr - rd_ptr`, modulo 2^(AW+1).
  - `full` when the pointer MSBs differ and the low bits are equal; `empty` when the pointers are equal. Both are combinational from the registered pointers.
- **Write and read**
  - Write accepted iff `write_enb && !full`: store {lfd_state, data_in} at `wr_ptr`, then `wr_ptr`+1. A write while full is dropped silently; no state change.
  - Read accepted iff `read_enb && !empty`: `data_out` <= entry data, `out_valid` <= 1, then `rd_ptr`+1. A read while empty: no state change, `out_valid` = 0, `data_out` holds.
- **Packet counter** (`pkt_cnt`, 7 bits)
  - Read of a tagged entry: `pkt_cnt` <= data[7:2] + 1, i.e. the payload length plus one for parity.
  - Read of an untagged entry with `pkt_cnt` > 0: `pkt_cnt` decrements.
  - The read that moves `pkt_cnt` from 1 to 0 also asserts `pkt_done` in the same cycle as that read's `out_valid`.
  - A header of length 0 gives `pkt_cnt` = 1; the next read is the parity byte.
  - Untagged read with `pkt_cnt` = 0 (orphan byte): output it normally, no `pkt_done`.
- **Simultaneous events**
  - Read and write in the same cycle, neither full nor empty: both proceed; `level` is unchanged.
  - When full: the read proceeds, the write is dropped (`full` is sampled from the start-of-cycle state).
  - When empty: the write proceeds, the read is ignored; no bypass.
- **soft_reset**
  - Priority over read and write.
  - Next edge: pointers = 0, `pkt_cnt` = 0, `data_out` = 0, `out_valid` = 0, `pkt_done` = 0. Array contents are not cleared.
- **reset**
  - Asynchronous, active-high. Same clears as `soft_reset`, applied immediately and independent of `clock`.
  - Output values while and after reset: `empty` = 1, `full` = 0, `level` = 0, `data_out` = 0, `out_valid` = 0, `pkt_done` = 0.
  - Reset mid-packet discards the remaining bytes; the first read after release must start from a new write.

## Timing
- Write-to-visible latency: 1 cycle. `empty` falls the edge after the first accepted write.
- Read latency: 1 cycle. `data_out`, `out_valid` and `pkt_done` update on the edge that samples `read_enb`.
- `full` rises on the edge of the DEPTH-th unmatched write. The producer samples `full` combinationally in the same cycle and must hold the byte.
- There is no combinational path from `read_enb` or `write_enb` to any output.
- Sustained throughput: one write and one read per cycle.

## Structure
- Shared package `router_pkg`:
  - `ROUTER_WIDTH` = 8, `ROUTER_FIFO_DEPTH` = 16.
  - Header field positions: `ADDR` [1:0], `LEN` [7:2].
  - `MAX_PAYLOAD` = 63.
- One natural sub-module: `router_fifo_mem`, a DEPTH x (WIDTH+1) register array with one write port and a registered read port. Pointer, counter and flag logic stays in `router_out_fifo`.

## Test plan
- Reset then idle -> `empty` = 1, `full` = 0, `level` = 0, `data_out` = 0; no pulses.
- Write header 0x0D (length 3, addr 01) with `lfd_state` = 1, then 3 payload bytes and parity 0xA5; read 5 times -> 5 `out_valid` pulses, data 0x0D, payload, 0xA5; `pkt_done` only on the 0xA5 read; `empty` = 1 after.
- 17 back-to-back writes -> `full` after the 16th, 17th dropped, `level` = 16. Then 16 reads return the first 16 bytes in order, checking pointer wrap.
- While full, assert read and write together -> read returns the oldest byte, write dropped, `level` = 15. While empty, assert both -> no `out_valid`, `level` = 1.
- Mid-packet `soft_reset` after 2 of 5 reads -> next edge `level` = 0, `data_out` = 0, `pkt_cnt` cleared. A new header of length 0 then gives `pkt_done` on its second read.
- Assert `reset` asynchronously between clock edges while `level` = 7 -> flags and outputs reach reset values before the next edge.

Source files
------------

// File: rtl/router_pkg.sv
// Shared router constants and the header byte layout.
package router_pkg;

   localparam int ROUTER_WIDTH      = 8;
   localparam int ROUTER_FIFO_DEPTH = 16;
   localparam int MAX_PAYLOAD       = 63;
   localparam int PKT_CNT_W         = 7;

   typedef struct packed {
      logic [5:0] len;
      logic [1:0] addr;
   } hdr_t;

endpackage

// File: rtl/router_out_fifo_if.sv
// Write/read/status bundle between the output FIFO and its neighbours.
interface router_out_fifo_if #(
   parameter int DEPTH = 16,
   parameter int WIDTH = 8
);

   logic                     write_enb;
   logic                     lfd_state;
   logic [WIDTH-1:0]         data_in;
   logic                     read_enb;
   logic [WIDTH-1:0]         data_out;
   logic                     out_valid;
   logic                     pkt_done;
   logic                     full;
   logic                     empty;
   logic [$clog2(DEPTH):0]   level;

   modport master (
      output write_enb, lfd_state, data_in, read_enb,
      input  data_out, out_valid, pkt_done, full, empty, level
   );

   modport slave (
      input  write_enb, lfd_state, data_in, read_enb,
      output data_out, out_valid, pkt_done, full, empty, level
   );

endinterface

// File: rtl/router_fifo_mem.sv
// Tagged FIFO storage: one write port, a combinational head peek
// and a registered data read port.
module router_fifo_mem #(
   parameter int DEPTH = 16,
   parameter int WIDTH = 8,
   localparam int AW   = $clog2(DEPTH)
) (
   input  logic           clock,
   input  logic           reset,
   input  logic           clear,
   input  logic           wr_en,
   input  logic [AW-1:0]  wr_addr,
   input  logic [WIDTH:0] wr_data,
   input  logic           rd_en,
   input  logic [AW-1:0]  rd_addr,
   output logic [WIDTH:0] head,
   output logic [WIDTH-1:0] q
);

   logic [WIDTH:0] mem [DEPTH];

   // Contents survive both resets; only the pointers are cleared.
   always_ff @(posedge clock) begin
      if (wr_en) mem[wr_addr] <= wr_data;
   end

   assign head = mem[rd_addr];

   always_ff @(posedge clock or posedge reset) begin
      if (reset)      q <= '0;
      else if (clear) q <= '0;
      else if (rd_en) q <= head[WIDTH-1:0];
   end

endmodule

// File: rtl/router_out_fifo.sv
// Per-port router output FIFO with header tagging and packet-end
// detection on the read side.
module router_out_fifo
   import router_pkg::*;
#(
   parameter int DEPTH = ROUTER_FIFO_DEPTH,
   parameter int WIDTH = ROUTER_WIDTH
) (
   input  logic clock,
   input  logic reset,
   input  logic soft_reset,
   router_out_fifo_if.slave bus
);

   localparam int AW = $clog2(DEPTH);

   logic [AW:0]           wr_ptr;
   logic [AW:0]           rd_ptr;
   logic [PKT_CNT_W-1:0]  pkt_cnt;
   logic [WIDTH:0]        head;
   logic                  full;
   logic                  empty;
   logic                  wr_go;
   logic                  rd_go;
   logic                  out_valid;
   logic                  pkt_done;
   hdr_t                  hdr;
   logic                  unused_addr;

   assign full  = (wr_ptr[AW] != rd_ptr[AW]) &&
                  (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
   assign empty = (wr_ptr == rd_ptr);

   assign wr_go = bus.write_enb && !full && !soft_reset;
   assign rd_go = bus.read_enb && !empty && !soft_reset;

   assign hdr         = head[7:0];
   assign unused_addr = &{1'b0, hdr.addr};

   router_fifo_mem #(
      .DEPTH (DEPTH),
      .WIDTH (WIDTH)
   ) u_mem (
      .clock   (clock),
      .reset   (reset),
      .clear   (soft_reset),
      .wr_en   (wr_go),
      .wr_addr (wr_ptr[AW-1:0]),
      .wr_data ({bus.lfd_state, bus.data_in}),
      .rd_en   (rd_go),
      .rd_addr (rd_ptr[AW-1:0]),
      .head    (head),
      .q       (bus.data_out)
   );

   always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
         wr_ptr    <= '0;
         rd_ptr    <= '0;
         pkt_cnt   <= '0;
         out_valid <= 1'b0;
         pkt_done  <= 1'b0;
      end else if (soft_reset) begin
         wr_ptr    <= '0;
         rd_ptr    <= '0;
         pkt_cnt   <= '0;
         out_valid <= 1'b0;
         pkt_done  <= 1'b0;
      end else begin
         out_valid <= rd_go;
         pkt_done  <= 1'b0;
         if (wr_go) wr_ptr <= wr_ptr + 1'b1;
         if (rd_go) begin
            rd_ptr <= rd_ptr + 1'b1;
            // Header loads payload length plus one for the parity byte.
            if (head[WIDTH]) begin
               pkt_cnt <= {1'b0, hdr.len} + 7'd1;
            end else if (pkt_cnt != '0) begin
               pkt_cnt  <= pkt_cnt - 1'b1;
               pkt_done <= (pkt_cnt == 7'd1);
            end
         end
      end
   end

   assign bus.out_valid = out_valid;
   assign bus.pkt_done  = pkt_done;
   assign bus.full      = full;
   assign bus.empty     = empty;
   assign bus.level     = wr_ptr - rd_ptr;

endmodule
